// File: rtl/fifo_input_packer.sv
// rtl/fifo_input_packer.sv - packs PAR_WRITE consecutive input words into one wide FIFO write
module fifo_input_packer #(
    parameter int              SIZE      = 16,
    parameter int              PAR_WRITE = 2,
    parameter logic [SIZE-1:0] PAD_VALUE = '0
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               clear,
    input  logic                               in_valid,
    input  logic [SIZE-1:0]                    in_data,
    output logic                               in_ready,
    input  logic                               flush,
    input  logic                               fifo_full,
    output logic                               fifo_wen,
    output logic [SIZE*PAR_WRITE-1:0]          fifo_din,
    output logic [$clog2(PAR_WRITE+1)-1:0]     lane_cnt
);

    localparam int LW = $clog2(PAR_WRITE + 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [LW-1:0]             lane_cnt_q, lane_cnt_d;
    logic [SIZE*PAR_WRITE-1:0] data_q, data_d;
    logic [LW-1:0]             fill_cnt;
    logic                      accept;

    assign in_ready = (state_q == FILL) | ((state_q == HOLD) & ~fifo_full);
    assign fifo_wen = (state_q == HOLD) & ~fifo_full;
    assign accept   = in_valid & in_ready;
    assign fifo_din = data_q;
    assign lane_cnt = lane_cnt_q;

    always_comb begin
        state_d    = state_q;
        lane_cnt_d = lane_cnt_q;
        data_d     = data_q;
        fill_cnt   = lane_cnt_q;

        case (state_q)
            FILL: begin
                if (accept) begin
                    for (int i = 0; i < PAR_WRITE; i++) begin
                        if (LW'(i) == lane_cnt_q) begin
                            data_d[i*SIZE +: SIZE] = in_data;
                        end
                    end
                    fill_cnt = lane_cnt_q + LW'(1);
                end
                lane_cnt_d = fill_cnt;
                // A completing accept wins over flush, so a full pack is never padded.
                if (fill_cnt == LW'(PAR_WRITE)) begin
                    state_d = HOLD;
                end else if (flush && (fill_cnt != '0)) begin
                    for (int i = 0; i < PAR_WRITE; i++) begin
                        if (LW'(i) >= fill_cnt) begin
                            data_d[i*SIZE +: SIZE] = PAD_VALUE;
                        end
                    end
                    state_d    = HOLD;
                    lane_cnt_d = LW'(PAR_WRITE);
                end
            end
            HOLD: begin
                if (!fifo_full) begin
                    if (accept) begin
                        // The word arriving during the write starts the next pack in lane 0.
                        data_d[0 +: SIZE] = in_data;
                        lane_cnt_d        = LW'(1);
                        state_d           = (PAR_WRITE == 1) ? HOLD : FILL;
                    end else begin
                        lane_cnt_d = '0;
                        state_d    = FILL;
                    end
                end
            end
            default: begin
                state_d    = FILL;
                lane_cnt_d = '0;
            end
        endcase

        if (clear) begin
            state_d    = FILL;
            lane_cnt_d = '0;
            data_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= FILL;
            lane_cnt_q <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            data_q     <= data_d;
        end
    end

endmodule
